// File: rtl/mem_stage.sv
// MEM stage: word loads/stores against local data memory with fixed wait states, feeding MEM/WB.
// Define MEM_ALIGN_CHECK_EN to suppress misaligned accesses and flag them on mem_misalign.
module mem_stage #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exmem_data_addr,
  input  logic [31:0] exmem_write_data,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_regwrite,
  input  logic        exmem_memtoreg,
  input  logic        exmem_memread,
  input  logic        exmem_memwrite,
  output logic [31:0] memwb_read_data,
  output logic [31:0] memwb_alu_result,
  output logic [4:0]  memwb_rd,
  output logic        memwb_regwrite,
  output logic        memwb_memtoreg,
  output logic        mem_stall,
  output logic        mem_misalign
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam bit          HasWait = (WAIT_STATES != 0);
  localparam logic [3:0]  CntInit = HasWait ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [31:0]   mem [DEPTH];

  logic          access;
  logic          stall;
  logic          misalign;
  logic          store_en;
  logic [AW-1:0] idx;
  logic [31:0]   rdata;

  assign access = exmem_memread || exmem_memwrite;
  // Upper address bits are dropped so accesses wrap modulo DEPTH words.
  assign idx    = exmem_data_addr[AW+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_q;

  assign misalign = access && (exmem_data_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign && !stall;
    end
  end

  assign mem_misalign = misalign_q;
`else
  assign misalign     = 1'b0;
  assign mem_misalign = 1'b0;
`endif

  // Stall depends only on FSM state and the request strobes.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      StIdle: stall = access && HasWait;
      StWait: stall = (cnt_q != 4'd0);
    endcase
  end

  assign mem_stall = stall;
  assign rdata     = misalign ? 32'h0 : mem[idx];
  assign store_en  = !rst && !stall && exmem_memwrite && !misalign;

  always_ff @(posedge clk) begin
    if (store_en) begin
      mem[idx] <= exmem_write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      cnt_q            <= 4'd0;
      memwb_read_data  <= 32'h0;
      memwb_alu_result <= 32'h0;
      memwb_rd         <= 5'd0;
      memwb_regwrite   <= 1'b0;
      memwb_memtoreg   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access && HasWait) begin
            state_q <= StWait;
            cnt_q   <= CntInit;
          end
        end
        StWait: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StIdle;
          end
        end
      endcase

      if (stall) begin
        // Bubble: control cleared, data fields held.
        memwb_rd       <= 5'd0;
        memwb_regwrite <= 1'b0;
        memwb_memtoreg <= 1'b0;
      end else begin
        memwb_read_data  <= rdata;
        memwb_alu_result <= exmem_data_addr;
        memwb_rd         <= exmem_rd;
        memwb_regwrite   <= exmem_regwrite;
        memwb_memtoreg   <= exmem_memtoreg;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance share inputs.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata;
  logic [4:0]  rd;
  logic        rw, mtr, mr, mw;

  logic [31:0] s_read_data, s_alu, f_read_data, f_alu;
  logic [4:0]  s_rd, f_rd;
  logic        s_regwrite, s_memtoreg, s_stall, s_misalign;
  logic        f_regwrite, f_memtoreg, f_stall, f_misalign;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst),
    .exmem_data_addr(addr), .exmem_write_data(wdata), .exmem_rd(rd),
    .exmem_regwrite(rw), .exmem_memtoreg(mtr), .exmem_memread(mr), .exmem_memwrite(mw),
    .memwb_read_data(s_read_data), .memwb_alu_result(s_alu), .memwb_rd(s_rd),
    .memwb_regwrite(s_regwrite), .memwb_memtoreg(s_memtoreg),
    .mem_stall(s_stall), .mem_misalign(s_misalign)
  );

  mem_stage #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .exmem_data_addr(addr), .exmem_write_data(wdata), .exmem_rd(rd),
    .exmem_regwrite(rw), .exmem_memtoreg(mtr), .exmem_memread(mr), .exmem_memwrite(mw),
    .memwb_read_data(f_read_data), .memwb_alu_result(f_alu), .memwb_rd(f_rd),
    .memwb_regwrite(f_regwrite), .memwb_memtoreg(f_memtoreg),
    .mem_stall(f_stall), .mem_misalign(f_misalign)
  );

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                       input logic w, input logic m2r, input logic rde, input logic wre);
    addr = a; wdata = d; rd = r; rw = w; mtr = m2r; mr = rde; mw = wre;
  endtask

  task automatic idle_inputs();
    drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Presents one EX/MEM entry and returns just after its completion edge with inputs idled.
  task automatic issue(input bit fast, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r, input logic w, input logic m2r, input logic rde,
                       input logic wre, output int stalls, output bit bubble_ok);
    drive(a, d, r, w, m2r, rde, wre);
    stalls    = 0;
    bubble_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!(fast ? f_stall : s_stall)) break;
      stalls++;
      if (i > 0 && (s_regwrite || s_memtoreg || s_rd != 5'd0)) bubble_ok = 1'b0;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    int idle_stalls;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (s_read_data !== 32'h0) begin failures++; $display("FAIL reset_read_data got=%h exp=0", s_read_data); end
    checks++; if (s_alu !== 32'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", s_alu); end
    checks++; if (s_rd !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", s_rd); end
    checks++; if (s_regwrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", s_regwrite); end
    checks++; if (s_memtoreg !== 1'b0) begin failures++; $display("FAIL reset_memtoreg got=%b exp=0", s_memtoreg); end
    checks++; if (s_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", s_stall); end
    checks++; if (s_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", s_misalign); end
    idle_stalls = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_stall !== 1'b0) idle_stalls++;
    end
    checks++; if (idle_stalls != 0) begin failures++; $display("FAIL idle_no_stall got=%0d exp=0", idle_stalls); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    int st; bit bok;
    issue(1'b0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, st, bok);
    checks++; if (st != 2) begin failures++; $display("FAIL store_stalls got=%0d exp=2", st); end
    checks++; if (s_alu !== 32'h10) begin failures++; $display("FAIL store_alu got=%h exp=10", s_alu); end
    issue(1'b0, 32'h10, 32'h0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, st, bok);
    checks++; if (st != 2) begin failures++; $display("FAIL load_stalls got=%0d exp=2", st); end
    checks++; if (!bok) begin failures++; $display("FAIL load_bubble got=0 exp=1"); end
    checks++; if (s_read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data got=%h exp=deadbeef", s_read_data); end
    checks++; if (s_rd !== 5'd5) begin failures++; $display("FAIL load_rd got=%0d exp=5", s_rd); end
    checks++; if (s_regwrite !== 1'b1) begin failures++; $display("FAIL load_regwrite got=%b exp=1", s_regwrite); end
    checks++; if (s_memtoreg !== 1'b1) begin failures++; $display("FAIL load_memtoreg got=%b exp=1", s_memtoreg); end
  endtask

  task automatic test_read_write_same();
    int st; bit bok;
    issue(1'b0, 32'hC, 32'h11111111, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, st, bok);
    issue(1'b0, 32'hC, 32'h22222222, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, st, bok);
    checks++; if (st != 2) begin failures++; $display("FAIL rw_stalls got=%0d exp=2", st); end
    checks++; if (s_read_data !== 32'h11111111) begin failures++; $display("FAIL rw_old_data got=%h exp=11111111", s_read_data); end
    issue(1'b0, 32'hC, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, st, bok);
    checks++; if (s_read_data !== 32'h22222222) begin failures++; $display("FAIL rw_new_data got=%h exp=22222222", s_read_data); end
  endtask

  task automatic test_reset_in_wait();
    int st; bit bok;
    issue(1'b0, 32'h20, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, st, bok);
    drive(32'h20, 32'h5A5A5A5A, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    // Back in IDLE, a still-presented access must stall afresh.
    @(negedge clk);
    checks++; if (s_stall !== 1'b1) begin failures++; $display("FAIL rst_wait_idle_stall got=%b exp=1", s_stall); end
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    issue(1'b0, 32'h20, 32'h0, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, st, bok);
    checks++; if (st != 2) begin failures++; $display("FAIL rst_wait_load_stalls got=%0d exp=2", st); end
    checks++; if (s_read_data !== 32'hA5A5A5A5) begin failures++; $display("FAIL rst_wait_mem got=%h exp=a5a5a5a5", s_read_data); end
  endtask

  task automatic test_misalign();
    int st; bit bok;
    issue(1'b0, 32'h20, 32'h13572468, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, st, bok);
    issue(1'b0, 32'h22, 32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, st, bok);
    checks++; if (st != 2) begin failures++; $display("FAIL mis_stalls got=%0d exp=2", st); end
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (s_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%b exp=1", s_misalign); end
    checks++; if (s_read_data !== 32'h0) begin failures++; $display("FAIL mis_read_data got=%h exp=0", s_read_data); end
    @(posedge clk); #1;
    checks++; if (s_misalign !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", s_misalign); end
    issue(1'b0, 32'h20, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, st, bok);
    checks++; if (s_read_data !== 32'h13572468) begin failures++; $display("FAIL mis_mem got=%h exp=13572468", s_read_data); end
`else
    checks++; if (s_misalign !== 1'b0) begin failures++; $display("FAIL mis_flag got=%b exp=0", s_misalign); end
    checks++; if (s_read_data !== 32'h13572468) begin failures++; $display("FAIL mis_read_data got=%h exp=13572468", s_read_data); end
    issue(1'b0, 32'h20, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, st, bok);
    checks++; if (s_read_data !== 32'hFFFFFFFF) begin failures++; $display("FAIL mis_mem got=%h exp=ffffffff", s_read_data); end
`endif
  endtask

  task automatic test_no_wait();
    int st; bit bok;
    issue(1'b1, 32'h1234, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, st, bok);
    checks++; if (st != 0) begin failures++; $display("FAIL nw_alu_stalls got=%0d exp=0", st); end
    checks++; if (f_alu !== 32'h1234) begin failures++; $display("FAIL nw_alu_result got=%h exp=1234", f_alu); end
    checks++; if (f_rd !== 5'd3 || f_regwrite !== 1'b1 || f_memtoreg !== 1'b0) begin
      failures++; $display("FAIL nw_alu_ctrl got=%0d/%b/%b exp=3/1/0", f_rd, f_regwrite, f_memtoreg);
    end
    issue(1'b1, 32'h10, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, st, bok);
    checks++; if (st != 0) begin failures++; $display("FAIL nw_store_stalls got=%0d exp=0", st); end
    issue(1'b1, 32'h410, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, st, bok);
    checks++; if (st != 0) begin failures++; $display("FAIL nw_load_stalls got=%0d exp=0", st); end
    checks++; if (f_read_data !== 32'hCAFEF00D) begin failures++; $display("FAIL nw_wrap_data got=%h exp=cafef00d", f_read_data); end
    checks++; if (f_alu !== 32'h410 || f_rd !== 5'd9) begin failures++; $display("FAIL nw_wrap_fields got=%h/%0d exp=410/9", f_alu, f_rd); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    test_reset();
    test_store_load();
    test_read_write_same();
    test_reset_in_wait();
    test_misalign();
    test_no_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
